// File: rtl/dmi_pkg.sv
// Shared types for the debug-module register-port sequencer.
package dmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Requester id doubles as the bit index into the arbiter request/grant vectors.
    typedef enum logic {
        REQ_J = 1'b0,
        REQ_S = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmi_rr_arb2.sv
// Two-input round-robin arbiter: a tie goes to the requester that was not granted last.
module dmi_rr_arb2
    import dmi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output req_id_e    last
);

    req_id_e last_q, last_d;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == REQ_J) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        if (gnt[1]) begin
            last_d = REQ_S;
        end else if (gnt[0]) begin
            last_d = REQ_J;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_S;
        end else begin
            last_q <= last_d;
        end
    end

    assign last = last_q;

endmodule

// File: rtl/dmi_core_req_arbiter.sv
// Core-clock sequencer sharing the DM register port between JTAG DMI pulses and an
// on-chip valid/ready agent: round-robin grant, one outstanding access, ack timeout.
module dmi_core_req_arbiter
    import dmi_pkg::*;
#(
    parameter int AW   = 7,
    parameter int DW   = 32,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          j_reg_en,
    input  logic          j_reg_wr_en,
    input  logic [AW-1:0] j_addr,
    input  logic [DW-1:0] j_wdata,
    output logic [DW-1:0] j_rdata,
    output logic          j_done,
    output logic          j_err,
    input  logic          j_err_clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_wr,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    output logic          s_rsp_valid,
    output logic [DW-1:0] s_rdata,
    output logic          s_rsp_err,
    output logic          dm_req,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata
);

    state_e          state_q, state_d;
    logic            j_pend_q, j_pend_d;
    logic            j_wr_q, j_wr_d;
    logic [AW-1:0]   j_addr_q, j_addr_d;
    logic [DW-1:0]   j_wdata_q, j_wdata_d;
    logic            dm_wr_q, dm_wr_d;
    logic [AW-1:0]   dm_addr_q, dm_addr_d;
    logic [DW-1:0]   dm_wdata_q, dm_wdata_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   j_rdata_q, j_rdata_d;
    logic            j_err_q, j_err_d;

    logic [1:0]      arb_req;
    logic            arb_en;
    logic [1:0]      gnt;
    req_id_e         owner;
    logic            gnt_j, gnt_s;
    logic [TO_W-1:0] timer_inc;
    logic            timeout;
    logic            j_accept;
    logic            err_set;

    assign arb_req = {s_valid, j_pend_q};
    assign arb_en  = (state_q == IDLE);
    assign gnt_j   = gnt[REQ_J];
    assign gnt_s   = gnt[REQ_S];

    // The last-grant register is updated on every grant, so it names the current owner.
    dmi_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .en    (arb_en),
        .gnt   (gnt),
        .last  (owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_j || gnt_s) state_d = BUSY;
            BUSY:    if (dm_ack || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_inc  = timer_q + TO_W'(1);
        timeout    = (state_q == BUSY) && !dm_ack && (timer_inc == '1);

        // A pulse in the cycle J is granted refills the pending slot instead of overrunning.
        j_accept   = j_reg_en && (!j_pend_q || gnt_j);
        j_pend_d   = j_accept ? 1'b1 : (gnt_j ? 1'b0 : j_pend_q);
        j_wr_d     = j_accept ? j_reg_wr_en : j_wr_q;
        j_addr_d   = j_accept ? j_addr : j_addr_q;
        j_wdata_d  = j_accept ? j_wdata : j_wdata_q;

        dm_wr_d    = dm_wr_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        timer_d    = timer_q;
        if (gnt_s) begin
            dm_wr_d    = s_wr;
            dm_addr_d  = s_addr;
            dm_wdata_d = s_wdata;
            timer_d    = '0;
        end else if (gnt_j) begin
            dm_wr_d    = j_wr_q;
            dm_addr_d  = j_addr_q;
            dm_wdata_d = j_wdata_q;
            timer_d    = '0;
        end else if (state_q == BUSY && !dm_ack) begin
            timer_d    = timer_inc;
        end

        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (state_q == BUSY && dm_ack) begin
            rsp_data_d = dm_wr_q ? '0 : dm_rdata;
            rsp_err_d  = 1'b0;
        end else if (timeout) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
        end

        j_rdata_d = j_rdata_q;
        if (state_q == RESP && owner == REQ_J) begin
            j_rdata_d = rsp_data_q;
        end

        // A new error outranks a clear arriving in the same cycle.
        err_set = (j_reg_en && !j_accept) ||
                  (state_q == RESP && owner == REQ_J && rsp_err_q);
        j_err_d = err_set || (j_err_q && !j_err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_pend_q   <= 1'b0;
            j_wr_q     <= 1'b0;
            j_addr_q   <= '0;
            j_wdata_q  <= '0;
            dm_wr_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            timer_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            j_rdata_q  <= '0;
            j_err_q    <= 1'b0;
        end else begin
            j_pend_q   <= j_pend_d;
            j_wr_q     <= j_wr_d;
            j_addr_q   <= j_addr_d;
            j_wdata_q  <= j_wdata_d;
            dm_wr_q    <= dm_wr_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            timer_q    <= timer_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            j_rdata_q  <= j_rdata_d;
            j_err_q    <= j_err_d;
        end
    end

    // dm_req decodes straight from the state flop so an async reset drops it at once.
    always_comb begin
        dm_req      = (state_q == BUSY);
        dm_wr       = dm_wr_q;
        dm_addr     = dm_addr_q;
        dm_wdata    = dm_wdata_q;
        s_ready     = gnt_s;
        j_done      = (state_q == RESP) && (owner == REQ_J);
        s_rsp_valid = (state_q == RESP) && (owner == REQ_S);
        s_rdata     = s_rsp_valid ? rsp_data_q : '0;
        s_rsp_err   = s_rsp_valid && rsp_err_q;
        j_rdata     = j_rdata_q;
        j_err       = j_err_q;
    end

endmodule

// File: tb/tb_dmi_core_req_arbiter.sv
// Directed and randomized bench for dmi_core_req_arbiter, checked against a
// transaction-level model of owner / pending request / response.
module tb_dmi_core_req_arbiter;

    localparam int AW       = 7;
    localparam int DW       = 32;
    localparam int TO_W     = 4;
    localparam int TO_LIMIT = (1 << TO_W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          j_reg_en, j_reg_wr_en, j_err_clr;
    logic [AW-1:0] j_addr;
    logic [DW-1:0] j_wdata;
    logic [DW-1:0] j_rdata;
    logic          j_done, j_err;
    logic          s_valid, s_ready, s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_rsp_valid, s_rsp_err;
    logic [DW-1:0] s_rdata;
    logic          dm_req, dm_wr, dm_ack;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;

    dmi_core_req_arbiter #(.AW(AW), .DW(DW), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .j_reg_en(j_reg_en), .j_reg_wr_en(j_reg_wr_en), .j_addr(j_addr), .j_wdata(j_wdata),
        .j_rdata(j_rdata), .j_done(j_done), .j_err(j_err), .j_err_clr(j_err_clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata), .s_rsp_err(s_rsp_err),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Field values applied with the next cycle's stimulus.
    logic          nx_jwr, nx_swr;
    logic [AW-1:0] nx_jaddr, nx_saddr;
    logic [DW-1:0] nx_jwdata, nx_swdata, nx_ackdata;

    // Reference model: who owns the DM port, whether it is answering, what J has queued.
    int            m_owner;     // -1 none, 0 J, 1 S
    bit            m_resp;
    bit            m_last;      // 0 J, 1 S
    bit            m_jp;
    logic          m_jwr, m_twr;
    logic [AW-1:0] m_jaddr, m_taddr;
    logic [DW-1:0] m_jwdata, m_twdata, m_data, m_jrdata;
    bit            m_err, m_jerr;
    int            m_cnt, n_jg, n_sg;

    // Observations of the DUT's own dm_req activity.
    logic [AW-1:0] grant_log[$];
    bit            prev_req;
    int            run_len, last_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_resp = 0; m_last = 1; m_jp = 0;
        m_jwr = 0; m_jaddr = '0; m_jwdata = '0;
        m_twr = 0; m_taddr = '0; m_twdata = '0;
        m_data = '0; m_err = 0; m_jrdata = '0; m_jerr = 0; m_cnt = 0;
        prev_req = 0; run_len = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic cyc(input bit jen = 0, input bit sv = 0, input bit ack = 0, input bit jclr = 0);
        bit e_busy, e_jdone, e_srsp, e_sready, j_gnt, s_gnt, set_err;
        @(posedge clk);
        #1;
        j_reg_en = jen; j_reg_wr_en = nx_jwr; j_addr = nx_jaddr; j_wdata = nx_jwdata;
        j_err_clr = jclr;
        s_valid = sv; s_wr = nx_swr; s_addr = nx_saddr; s_wdata = nx_swdata;
        dm_ack = ack; dm_rdata = nx_ackdata;
        @(negedge clk);

        e_busy   = (m_owner != -1) && !m_resp;
        e_jdone  = m_resp && (m_owner == 0);
        e_srsp   = m_resp && (m_owner == 1);
        e_sready = (m_owner == -1) && sv && (!m_jp || m_last == 0);
        check("dm_req",      32'(dm_req),      32'(e_busy));
        check("dm_wr",       32'(dm_wr),       32'(m_twr));
        check("dm_addr",     32'(dm_addr),     32'(m_taddr));
        check("dm_wdata",    dm_wdata,         m_twdata);
        check("s_ready",     32'(s_ready),     32'(e_sready));
        check("j_done",      32'(j_done),      32'(e_jdone));
        check("j_rdata",     j_rdata,          m_jrdata);
        check("j_err",       32'(j_err),       32'(m_jerr));
        check("s_rsp_valid", 32'(s_rsp_valid), 32'(e_srsp));
        check("s_rdata",     s_rdata,          e_srsp ? m_data : 32'h0);
        check("s_rsp_err",   32'(s_rsp_err),   32'(e_srsp && m_err));

        if (dm_req && !prev_req) grant_log.push_back(dm_addr);
        if (dm_req) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        prev_req = dm_req;

        j_gnt = 0; s_gnt = 0; set_err = 0;
        if (m_resp) begin
            if (m_owner == 0) begin
                m_jrdata = m_data;
                set_err  = m_err;
            end
            m_owner = -1;
            m_resp  = 0;
        end else if (m_owner != -1) begin
            if (ack) begin
                m_resp = 1; m_data = m_twr ? 32'h0 : nx_ackdata; m_err = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TO_LIMIT) begin
                    m_resp = 1; m_data = 32'h0; m_err = 1;
                end
            end
        end else begin
            if (m_jp && sv) begin
                if (m_last == 0) s_gnt = 1; else j_gnt = 1;
            end else begin
                j_gnt = m_jp;
                s_gnt = sv;
            end
            if (j_gnt) begin
                m_owner = 0; m_last = 0; m_jp = 0; n_jg++;
                m_twr = m_jwr; m_taddr = m_jaddr; m_twdata = m_jwdata;
            end
            if (s_gnt) begin
                m_owner = 1; m_last = 1; n_sg++;
                m_twr = nx_swr; m_taddr = nx_saddr; m_twdata = nx_swdata;
            end
            m_cnt = 0;
        end
        if (jen) begin
            if (!m_jp) begin
                m_jp = 1; m_jwr = nx_jwr; m_jaddr = nx_jaddr; m_jwdata = nx_jwdata;
            end else begin
                set_err = 1;
            end
        end
        m_jerr = set_err ? 1'b1 : (jclr ? 1'b0 : m_jerr);
    endtask

    initial begin
        int jp_issued;
        rst_n = 1'b0;
        j_reg_en = 0; j_reg_wr_en = 0; j_addr = '0; j_wdata = '0; j_err_clr = 0;
        s_valid = 0; s_wr = 0; s_addr = '0; s_wdata = '0; dm_ack = 0; dm_rdata = '0;
        nx_jwr = 0; nx_swr = 0; nx_jaddr = '0; nx_saddr = '0;
        nx_jwdata = '0; nx_swdata = '0; nx_ackdata = '0;
        n_jg = 0; n_sg = 0; last_run = 0;
        model_reset();

        // Reset state.
        #12;
        check("rst_dm_req",  32'(dm_req),      32'h0);
        check("rst_j_done",  32'(j_done),      32'h0);
        check("rst_s_rsp",   32'(s_rsp_valid), 32'h0);
        check("rst_j_err",   32'(j_err),       32'h0);
        check("rst_j_rdata", j_rdata,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // J read, ack after three request cycles.
        nx_jwr = 0; nx_jaddr = 7'h10; nx_ackdata = 32'hDEAD_BEEF;
        cyc(.jen(1));
        cyc();
        repeat (3) cyc();
        cyc(.ack(1));
        cyc();
        check("j_done_at_ack_plus1", 32'(j_done), 32'h1);
        cyc();
        check("j_rdata_deadbeef", j_rdata, 32'hDEAD_BEEF);

        // S write acked in its first request cycle.
        nx_swr = 1; nx_saddr = 7'h05; nx_swdata = 32'h1234_5678;
        cyc(.sv(1));
        cyc(.ack(1));
        cyc();
        check("s_wr_rsp_valid", 32'(s_rsp_valid), 32'h1);
        check("s_wr_rsp_err",   32'(s_rsp_err),   32'h0);
        cyc();
        check("s_wr_req_len",   32'(last_run),    32'h1);

        // J and S both keep requesting: grants must alternate J,S,J,S.
        grant_log.delete();
        n_jg = 0; n_sg = 0;
        nx_jaddr = 7'h21; nx_saddr = 7'h42; nx_swr = 0; nx_ackdata = 32'hA5A5_0001;
        cyc(.jen(1));
        jp_issued = 1;
        for (int i = 0; i < 80; i++) begin
            bit want_j;
            want_j = (jp_issued < 2) && !m_jp;
            cyc(.jen(want_j), .sv(n_sg < 2), .ack(m_owner != -1 && !m_resp));
            if (want_j) jp_issued++;
            if (n_sg == 2 && n_jg == 2 && m_owner == -1) break;
        end
        check("alt_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'h21 : 32'h42);

        // S read with no ack: request must drop after the timeout.
        nx_swr = 0; nx_saddr = 7'h07;
        cyc(.sv(1));
        for (int i = 0; i < TO_LIMIT + 1 && !m_resp; i++) cyc();
        check("timeout_resp_due", 32'(m_resp), 32'h1);
        cyc();
        check("timeout_rsp_err",   32'(s_rsp_err), 32'h1);
        check("timeout_rdata",     s_rdata,        32'h0);
        check("timeout_req_len",   32'(last_run),  32'(TO_LIMIT));
        cyc();

        // Overrun: third pulse lands while J is busy and another is pending.
        nx_jaddr = 7'h30; nx_ackdata = 32'h0BAD_F00D;
        cyc(.jen(1));
        cyc();
        cyc(.jen(1));
        cyc(.jen(1));
        cyc();
        check("overrun_j_err", 32'(j_err), 32'h1);
        cyc(.ack(1));
        cyc();
        check("overrun_first_done", 32'(j_done), 32'h1);
        cyc();
        cyc(.ack(1));
        cyc();
        cyc(.jclr(1));
        cyc();
        check("j_err_cleared", 32'(j_err), 32'h0);

        // Reset while an S access is outstanding.
        nx_saddr = 7'h11;
        cyc(.sv(1));
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dm_req", 32'(dm_req),      32'h0);
        check("midrst_s_rsp",  32'(s_rsp_valid), 32'h0);
        j_reg_en = 0; s_valid = 0; dm_ack = 0; j_err_clr = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            nx_jwr = 1'($urandom); nx_swr = 1'($urandom);
            nx_jaddr = AW'($urandom); nx_saddr = AW'($urandom);
            nx_jwdata = $urandom; nx_swdata = $urandom; nx_ackdata = $urandom;
            cyc(.jen($urandom_range(0, 4) == 0), .sv($urandom_range(0, 2) == 0),
                .ack(m_owner != -1 && !m_resp && $urandom_range(0, 2) == 0),
                .jclr($urandom_range(0, 9) == 0));
        end
        repeat (TO_LIMIT + 4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
